// File: rtl/shift_reg_sipo_rx_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver: FSM state
// encoding, default word width and a counter-sizing helper.
package shift_reg_pkg;

    // Receiver FSM states: waiting for a frame start, or assembling a word.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sipo_state_e;

    localparam int DEFAULT_WIDTH = 4;

    // Bit counter width able to hold the values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : shift_reg_pkg

// File: rtl/shift_reg_sipo_rx_if.sv
// Serial input and parallel output bundle of the SIPO receiver.
// slave is the receiver side, master is the producer/consumer side.
interface shift_reg_sipo_rx_if
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             sdi;
    logic             sdi_en;
    logic             frame_start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             frame_err;
    logic             overrun;
    logic             overrun_clr;

    modport slave (
        input  sdi,
        input  sdi_en,
        input  frame_start,
        input  dout_ready,
        input  overrun_clr,
        output dout,
        output dout_valid,
        output frame_err,
        output overrun
    );

    modport master (
        output sdi,
        output sdi_en,
        output frame_start,
        output dout_ready,
        output overrun_clr,
        input  dout,
        input  dout_valid,
        input  frame_err,
        input  overrun
    );

endinterface : shift_reg_sipo_rx_if

// File: rtl/shift_reg_sipo_rx_hold_reg.sv
// Output holding register of the SIPO receiver: keeps the last completed
// word for the consumer under a valid/ready handshake and flags words that
// had to be dropped because the previous one was still unconsumed.
module sipo_hold_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_word,
    input  logic             dout_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;
    logic             overrun_r;

    logic             xfer_s;
    logic             accept_s;
    logic             drop_s;

    // Decode handshake, load acceptance and word drop for this edge.
    always_comb begin
        xfer_s   = 1'b0;
        accept_s = 1'b0;
        drop_s   = 1'b0;
        xfer_s   = dout_valid_r & dout_ready;
        if (load_en) begin
            // The slot is free, or it is being emptied on this very edge.
            if (!dout_valid_r || dout_ready) begin
                accept_s = 1'b1;
            end else begin
                drop_s   = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end
    end

    // Held word and its valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
        end else if (accept_s) begin
            dout_r       <= load_word;
            dout_valid_r <= 1'b1;
        end else if (xfer_s) begin
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= dout_valid_r;
        end
    end

    // Sticky overrun flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (overrun_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign overrun    = overrun_r;

endmodule : sipo_hold_reg

// File: rtl/shift_reg_sipo_rx.sv
// Serial-in/parallel-out receiver. Bits arrive MSB first, qualified by
// sdi_en; frame_start marks the first bit of a word. The FSM, bit counter
// and shifter live here; the output slot is handled by sipo_hold_reg.
module shift_reg_sipo_rx
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                 clk,
    input logic                 reset,
    shift_reg_sipo_rx_if.slave  bus
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    sipo_state_e       state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  shreg_r;
    logic              frame_err_r;

    logic              restart_s;
    logic              complete_s;
    logic [WIDTH-1:0]  word_s;
    logic [WIDTH-1:0]  first_bit_s;

    logic [WIDTH-1:0]  hold_dout_s;
    logic              hold_valid_s;
    logic              hold_overrun_s;

    // Classify the sampled bit: restart of a partial word, or last bit.
    always_comb begin
        restart_s   = 1'b0;
        complete_s  = 1'b0;
        word_s      = {shreg_r[WIDTH-2:0], bus.sdi};
        first_bit_s = {{(WIDTH-1){1'b0}}, bus.sdi};
        if ((state_r == ST_SHIFT) && bus.sdi_en) begin
            if (bus.frame_start) begin
                restart_s = 1'b1;
            end else if (cnt_r == LAST_CNT) begin
                complete_s = 1'b1;
            end else begin
                complete_s = 1'b0;
            end
        end else begin
            restart_s  = 1'b0;
            complete_s = 1'b0;
        end
    end

    // Receive FSM with bit counter, shifter and framing-error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            shreg_r     <= {WIDTH{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= restart_s;
            case (state_r)
                ST_IDLE: begin
                    // Only a marked first bit opens a word; others are discarded.
                    if (bus.sdi_en && bus.frame_start) begin
                        shreg_r <= first_bit_s;
                        cnt_r   <= CNT_ONE;
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (!bus.sdi_en) begin
                        state_r <= ST_SHIFT;
                    end else if (bus.frame_start) begin
                        // Partial word abandoned; current bit starts a new one.
                        shreg_r <= first_bit_s;
                        cnt_r   <= CNT_ONE;
                        state_r <= ST_SHIFT;
                    end else if (complete_s) begin
                        shreg_r <= word_s;
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_IDLE;
                    end else begin
                        shreg_r <= word_s;
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk         (clk),
        .reset       (reset),
        .load_en     (complete_s),
        .load_word   (word_s),
        .dout_ready  (bus.dout_ready),
        .overrun_clr (bus.overrun_clr),
        .dout        (hold_dout_s),
        .dout_valid  (hold_valid_s),
        .overrun     (hold_overrun_s)
    );

    assign bus.dout       = hold_dout_s;
    assign bus.dout_valid = hold_valid_s;
    assign bus.overrun    = hold_overrun_s;
    assign bus.frame_err  = frame_err_r;

endmodule : shift_reg_sipo_rx

// File: doc/shift_reg_sipo_rx.md
SHIFT_REG_SIPO_RX -- requirements
Module: shift_reg_sipo_rx

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the deserialised word width; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset, sampled on posedge clk only.
REQ-004 sdi  input  1  SHALL carry serial data, MSB of each word first.
REQ-005 sdi_en  input  1  SHALL qualify sdi; a bit is sampled only on edges where sdi_en=1.
REQ-006 frame_start  input  1  SHALL mark the sampled bit as word bit WIDTH-1; ignored when sdi_en=0.
REQ-007 dout  output  WIDTH  SHALL present the held received word.
REQ-008 dout_valid  output  1  SHALL be high while dout holds an unconsumed word.
REQ-009 dout_ready  input  1  SHALL be the consumer accept; transfer occurs on an edge with dout_valid=1 and dout_ready=1.
REQ-010 frame_err  output  1  SHALL pulse high for one cycle when a word is aborted by a new frame_start.
REQ-011 overrun  output  1  SHALL be a sticky flag set when a completed word is dropped.
REQ-012 overrun_clr  input  1  SHALL clear overrun on the next edge.

Function
REQ-013 The FSM SHALL have two states: IDLE and SHIFT.
REQ-014 IDLE: sampled bits without frame_start SHALL be discarded; sdi_en=1 and frame_start=1 SHALL load sdi into shift bit 0, set bit count to 1, and go to SHIFT.
REQ-015 SHIFT: each sampled bit SHALL shift in as {shreg[WIDTH-2:0], sdi} and increment the count; sdi_en=0 SHALL hold state.
REQ-016 When the WIDTH-th bit is sampled, the word SHALL be complete on that edge and the FSM SHALL return to IDLE.
REQ-017 A completed word SHALL load dout and set dout_valid on the completion edge (visible one cycle after the last-bit edge).
REQ-018 A handshake with no completion on the same edge SHALL clear dout_valid; dout SHALL hold its value.
REQ-019 Completion and handshake on the same edge SHALL load the new word, with dout_valid staying 1.
REQ-020 Completion with dout_valid=1 and dout_ready=0 SHALL drop the new word, keep the old dout, and set overrun.
REQ-021 frame_start with sdi_en=1 while in SHIFT SHALL discard the partial word, restart the count at 1 with the current sdi bit, stay in SHIFT, and pulse frame_err.
REQ-022 overrun_clr and a new overrun event on the same edge SHALL leave overrun set (set wins).
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide and never exceed WIDTH.

Reset
REQ-024 reset=1 SHALL force state=IDLE, count=0, shift register=0, dout=0, dout_valid=0, frame_err=0, overrun=0 on the next edge.
REQ-025 reset SHALL override all other inputs, including mid-word and with a pending word, which is lost.
REQ-026 The first bit accepted after reset deasserts SHALL require frame_start.

Structure
REQ-027 Shared package shift_reg_pkg SHALL hold the FSM state encoding (IDLE=0, SHIFT=1) and DEFAULT_WIDTH=4.
REQ-028 The output holding register with its valid/ready/overrun logic SHALL be a sub-module named sipo_hold_reg; the FSM, counter and shifter stay in the top module.
REQ-029 The block SHALL accept the sdo stream of the team's 4-bit parallel-load shift register directly when WIDTH=4.

Verification
REQ-030 Basic: WIDTH=4, dout_ready=1, frame_start on the first of bits 0,1,0,1 on 4 consecutive edges -> dout=4'h5, dout_valid=1 for exactly one cycle, one cycle after the 4th edge.
REQ-031 Gapped: bits 1,1,0,1 with sdi_en low for 2 cycles between bits -> dout=4'hD; no output before the 4th sampled bit.
REQ-032 Backpressure: dout_ready=0, words 4'hA then 4'h3 -> dout stays 4'hA, overrun=1; overrun_clr -> overrun=0 next cycle.
REQ-033 Same-edge: word 4'h6 pending, 4'h9 completes on the edge where dout_ready=1 -> dout=4'h9, dout_valid held at 1, overrun=0.
REQ-034 Restart: 2 bits sent, then frame_start with bits 0,0,1,1 -> one-cycle frame_err pulse, dout=4'h3.
REQ-035 Reset mid-word: reset=1 after 3 bits of a word -> all outputs 0 next edge; a following 4th bit without frame_start produces no word.
